// File: rtl/data_wrapper.sv
// data_wrapper: byte-stream framer.
// Each contiguous rx_dv run is buffered as one packet in a payload FIFO and
// re-emitted as preamble, SFD, payload, 1-byte XOR FCS, then an idle gap.
// Ports:
//   clk    - clock, all logic on rising edge
//   rst    - asynchronous active-high reset, clears all state
//   rxd    - receive byte, sampled when rx_dv=1
//   rx_dv  - receive valid; a maximal run of 1s is one packet
//   txd    - transmit byte (registered, 00 when tx_en=0)
//   tx_en  - transmit enable (registered), high for every frame byte
module data_wrapper #(
  parameter int         PRE_LEN    = 7,
  parameter logic [7:0] PRE_BYTE   = 8'h55,
  parameter logic [7:0] SFD_BYTE   = 8'hD5,
  parameter int         IFG_LEN    = 2,
  parameter int         FIFO_DEPTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rxd,
  input  logic       rx_dv,
  output logic [7:0] txd,
  output logic       tx_en
);
  localparam int         AW    = $clog2(FIFO_DEPTH);
  localparam int         PW    = AW + 1;
  localparam logic [7:0] PRE_L = 8'(PRE_LEN);
  localparam logic [7:0] IFG_L = 8'(IFG_LEN);

  typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, FCS, IFG} state_t;

  // ---------------- input stage + FIFO ----------------
  logic [7:0]            hold_d;
  logic                  hold_vld;
  logic                  drop;       // rest of current packet is discarded
  logic                  pkt_wrote;  // current packet has >=1 accepted entry
  logic [7:0]            mem_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] mem_e;
  logic [AW:0]           wr_ptr, rd_ptr;
  logic [AW-1:0]         last_idx;
  logic                  full, empty, push_req, push, pop, ovf, hold_eop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // The held byte is the last of its packet when rx_dv has dropped by now.
  assign hold_eop = !rx_dv;
  assign push_req = hold_vld && !drop;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign push     = push_req && (!full || pop);
  assign ovf      = push_req && full && !pop;
  assign last_idx = wr_ptr[AW-1:0] - AW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_vld  <= 1'b0;
      hold_d    <= 8'h00;
      drop      <= 1'b0;
      pkt_wrote <= 1'b0;
      wr_ptr    <= '0;
    end else begin
      hold_vld <= rx_dv;
      if (rx_dv) hold_d <= rxd;
      if (push)  wr_ptr <= wr_ptr + PW'(1);
      if (hold_vld) begin
        if (hold_eop) begin
          drop      <= 1'b0;
          pkt_wrote <= 1'b0;
        end else begin
          if (ovf)  drop      <= 1'b1;
          if (push) pkt_wrote <= 1'b1;
        end
      end
    end
  end

  // On overflow the newest entry is still unread (FIFO full, no pop), so it
  // can be retagged as EOP to close the truncated frame.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_d[wr_ptr[AW-1:0]] <= hold_d;
      mem_e[wr_ptr[AW-1:0]] <= hold_eop;
    end else if (ovf && pkt_wrote) begin
      mem_e[last_idx] <= 1'b1;
    end
  end

  // ---------------- output FSM ----------------
  // state names what is currently on the line.
  state_t     state, state_n;
  logic [7:0] cnt, cnt_n, acc, acc_n, txd_n, rd_d;
  logic       tx_en_n, last_eop, last_eop_n, rd_e;

  assign rd_d = mem_d[rd_ptr[AW-1:0]];
  assign rd_e = mem_e[rd_ptr[AW-1:0]];

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    acc_n      = acc;
    last_eop_n = last_eop;
    txd_n      = 8'h00;
    tx_en_n    = 1'b0;
    pop        = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        state_n = PRE;
        cnt_n   = 8'd1;
        acc_n   = 8'h00;
        txd_n   = PRE_BYTE;
        tx_en_n = 1'b1;
      end
      PRE: begin
        tx_en_n = 1'b1;
        if (cnt == PRE_L) begin
          state_n = SFD;
          txd_n   = SFD_BYTE;
        end else begin
          cnt_n = cnt + 8'd1;
          txd_n = PRE_BYTE;
        end
      end
      SFD: begin
        state_n    = DATA;
        last_eop_n = 1'b0;
      end
      DATA: if (last_eop) begin
        state_n = FCS;
        txd_n   = acc;
        tx_en_n = 1'b1;
      end
      FCS: begin
        state_n = (IFG_LEN > 1) ? IFG : IDLE;
        cnt_n   = 8'd1;
      end
      IFG: begin
        if (cnt == IFG_L - 8'd1) state_n = IDLE;
        else                     cnt_n   = cnt + 8'd1;
      end
      default: state_n = IDLE;
    endcase
    // Payload fetch: from SFD into the first byte, and within DATA until the
    // EOP entry has gone out. An empty FIFO here just stalls with tx_en=0.
    if ((state == SFD || (state == DATA && !last_eop)) && !empty) begin
      pop        = 1'b1;
      txd_n      = rd_d;
      tx_en_n    = 1'b1;
      acc_n      = acc ^ rd_d;
      last_eop_n = rd_e;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 8'h00;
      acc      <= 8'h00;
      last_eop <= 1'b0;
      rd_ptr   <= '0;
      txd      <= 8'h00;
      tx_en    <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      acc      <= acc_n;
      last_eop <= last_eop_n;
      txd      <= txd_n;
      tx_en    <= tx_en_n;
      if (pop) rd_ptr <= rd_ptr + PW'(1);
    end
  end
endmodule

// File: tb/tb_data_wrapper.sv
module tb_data_wrapper;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rxd = 8'h00, rxd4 = 8'h00;
  logic       rx_dv = 1'b0, rx_dv4 = 1'b0;
  logic [7:0] txd, txd4;
  logic       tx_en, tx_en4;

  int errs = 0, checks = 0;
  logic [7:0] fq[$];   // captured frame bytes
  logic [7:0] pl[$];   // expected payload
  logic [8:0] st[$];   // stimulus {rx_dv, rxd}
  int wt;

  always #5 clk = ~clk;

  data_wrapper dut (
    .clk(clk), .rst(rst), .rxd(rxd), .rx_dv(rx_dv), .txd(txd), .tx_en(tx_en)
  );
  data_wrapper #(.FIFO_DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .rxd(rxd4), .rx_dv(rx_dv4), .txd(txd4), .tx_en(tx_en4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic txe(input bit s);
    return s ? tx_en4 : tx_en;
  endfunction
  function automatic logic [7:0] txv(input bit s);
    return s ? txd4 : txd;
  endfunction

  task automatic send(input bit s);
    foreach (st[i]) begin
      @(negedge clk);
      if (s) begin rx_dv4 = st[i][8]; rxd4 = st[i][7:0]; end
      else   begin rx_dv  = st[i][8]; rxd  = st[i][7:0]; end
    end
    @(negedge clk);
    rx_dv = 1'b0; rx_dv4 = 1'b0; rxd = 8'h00; rxd4 = 8'h00;
  endtask

  // wt counts negedges until tx_en is seen high (inclusive).
  task automatic collect(input bit s, output int w);
    fq.delete();
    w = 0;
    do begin @(negedge clk); w++; end while (!txe(s) && w < 300);
    if (!txe(s)) begin
      check("frame_timeout", 32'(txe(s)), 32'd1);
      return;
    end
    while (txe(s) && fq.size() < 64) begin
      fq.push_back(txv(s));
      @(negedge clk);
    end
    check("idle_txd", 32'(txv(s)), 32'h00);
  endtask

  task automatic cmp_frame(input string tag, input logic [7:0] fcs);
    int n;
    logic [7:0] e;
    n = 7 + 1 + pl.size() + 1;
    check({tag, "_len"}, 32'(fq.size()), 32'(n));
    for (int i = 0; i < n && i < fq.size(); i++) begin
      if (i < 7)                 e = 8'h55;
      else if (i == 7)           e = 8'hD5;
      else if (i < 8 + pl.size()) e = pl[i-8];
      else                       e = fcs;
      check($sformatf("%s_b%0d", tag, i), 32'(fq[i]), 32'(e));
    end
  endtask

  initial begin
    // 1: reset state
    repeat (2) @(negedge clk);
    check("rst_txd", 32'(txd), 32'h00);
    check("rst_tx_en", 32'(tx_en), 32'd0);
    check("rst_tx_en4", 32'(tx_en4), 32'd0);
    rst = 1'b0;

    // 2: single byte; tx_en first seen on the 4th negedge counted from the
    // driving one (2 edges after the sampling edge)
    st = '{9'h16E};
    fork send(0); collect(0, wt); join
    check("t2_latency", 32'(wt), 32'd4);
    pl = '{8'h6E};
    cmp_frame("t2", 8'h6E);
    @(negedge clk);
    check("t2_ifg", 32'(tx_en), 32'd0);
    repeat (4) @(negedge clk);

    // 3: back-to-back packets, 2-cycle gap between frames
    st.delete();
    st.push_back(9'h16E); st.push_back(9'h000);
    repeat (5) st.push_back(9'h182);
    fork send(0); collect(0, wt); join
    check("t3_latency", 32'(wt), 32'd4);
    pl = '{8'h6E};
    cmp_frame("t3f1", 8'h6E);
    collect(0, wt);
    check("t3_gap", 32'(wt), 32'd2);
    pl.delete();
    repeat (5) pl.push_back(8'h82);
    cmp_frame("t3f2", 8'h82);
    repeat (4) @(negedge clk);

    // 4: multi-byte FCS
    st = '{9'h101, 9'h102, 9'h103};
    fork send(0); collect(0, wt); join
    pl = '{8'h01, 8'h02, 8'h03};
    cmp_frame("t4a", 8'h00);
    repeat (4) @(negedge clk);
    st = '{9'h1A5, 9'h10F};
    fork send(0); collect(0, wt); join
    pl = '{8'hA5, 8'h0F};
    cmp_frame("t4b", 8'hAA);
    repeat (4) @(negedge clk);

    // 5: reset mid-DATA acts without an edge; FIFO leftovers are gone
    st = '{9'h121, 9'h122, 9'h123, 9'h124, 9'h125};
    send(0);
    repeat (7) @(negedge clk);
    check("t5_in_data_en", 32'(tx_en), 32'd1);
    check("t5_in_data_txd", 32'(txd), 32'h22);
    #2 rst = 1'b1;
    #1;
    check("t5_async_en", 32'(tx_en), 32'd0);
    check("t5_async_txd", 32'(txd), 32'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    st = '{9'h111};
    fork send(0); collect(0, wt); join
    check("t5_latency", 32'(wt), 32'd4);
    pl = '{8'h11};
    cmp_frame("t5", 8'h11);
    repeat (4) @(negedge clk);

    // 6: overflow on the 4-deep instance. Entries 01..04 fill it before the
    // first pop (which comes after the header), so 05 overflows and 04 is
    // retagged as EOP: payload 01..04, FCS 01^02^03^04 = 04.
    st.delete();
    for (int i = 1; i <= 12; i++) st.push_back({1'b1, 8'(i)});
    fork send(1); collect(1, wt); join
    check("t6_latency", 32'(wt), 32'd4);
    pl = '{8'h01, 8'h02, 8'h03, 8'h04};
    cmp_frame("t6", 8'h04);
    begin
      int hi = 0;
      repeat (30) @(negedge clk) if (tx_en4) hi++;
      check("t6_no_extra", 32'(hi), 32'd0);
    end
    st = '{9'h13C};
    fork send(1); collect(1, wt); join
    pl = '{8'h3C};
    cmp_frame("t6_recover", 8'h3C);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
